// File: rtl/uvmt_obi_st_chkr_pkg.sv
// Shared definitions for the OBI protocol checker: error flag indices,
// flag and counter widths, and a saturating increment helper.
package uvmt_obi_st_chkr_pkg;

   localparam int ERR_WIDTH = 5;
   localparam int CNT_WIDTH = 32;

   typedef enum int unsigned {
      ERR_STABILITY = 0,
      ERR_UNEXP_RSP = 1,
      ERR_OVERFLOW  = 2,
      ERR_ZERO_BE   = 3,
      ERR_TIMEOUT   = 4
   } err_idx_e;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/uvmt_obi_st_chkr_fifo.sv
// In-order tracking FIFO for accepted OBI transactions.
// Head entry is visible combinationally on rdata while not empty.
module uvmt_obi_st_chkr_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Explicit wrap so non-power-of-two depths stay in range.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/uvmt_obi_st_prot_chkr.sv
// OBI protocol checker: address-phase stability, in-order response tracking,
// overflow, zero byte-enable and head-of-line response timeout.
module uvmt_obi_st_prot_chkr
   import uvmt_obi_st_chkr_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int RSP_TIMEOUT     = 256,
   parameter bit USE_RREADY      = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req,
   input  logic                    gnt,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    rvalid,
   input  logic                    rready,
   output logic [ERR_WIDTH-1:0]    err_pulse,
   output logic [ERR_WIDTH-1:0]    err_sticky,
   output logic [4:0]              outstanding,
   output logic [CNT_WIDTH-1:0]    n_reads,
   output logic [CNT_WIDTH-1:0]    n_writes
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
   localparam int EW   = 1 + CNT_WIDTH;

   logic                  accept;
   logic                  complete;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [CW-1:0]         count;
   logic [EW-1:0]         head;
   logic [CNT_WIDTH-1:0]  now_reg;
   logic [CNT_WIDTH-1:0]  age;
   logic                  fired_reg;
   logic                  timeout_hit;
   logic                  hold_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  we_reg;
   logic [BE_W-1:0]       be_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [ERR_WIDTH-1:0]  err_next;

   assign accept   = req & gnt;
   assign complete = rvalid & (rready | ~USE_RREADY);
   assign pop      = complete & ~empty;
   // A same-cycle completion frees the slot the new accept needs.
   assign push     = accept & (~full | pop);

   // Entries carry {we, accept timestamp}; head age is now minus timestamp.
   uvmt_obi_st_chkr_fifo #(
      .WIDTH (EW),
      .DEPTH (MAX_OUTSTANDING),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wdata   ({we, now_reg + CNT_WIDTH'(1)}),
      .rdata   (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign age         = now_reg - head[CNT_WIDTH-1:0];
   assign outstanding = 5'(count);

   generate
      if (RSP_TIMEOUT == 0) begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end else begin : g_timeout
         assign timeout_hit = ~empty & ~pop & ~fired_reg &
                              (age + CNT_WIDTH'(1) >= CNT_WIDTH'(RSP_TIMEOUT));
      end
   endgenerate

   always_comb begin
      err_next                = '0;
      err_next[ERR_STABILITY] = hold_reg & (~req || addr != addr_reg || we != we_reg ||
                                            be != be_reg || (we_reg && wdata != wdata_reg));
      err_next[ERR_UNEXP_RSP] = complete & empty;
      err_next[ERR_OVERFLOW]  = accept & full & ~complete;
      err_next[ERR_ZERO_BE]   = accept & (be == '0);
      err_next[ERR_TIMEOUT]   = timeout_hit;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_reg  <= 1'b0;
         addr_reg  <= '0;
         we_reg    <= 1'b0;
         be_reg    <= '0;
         wdata_reg <= '0;
      end else begin
         hold_reg <= req & ~gnt;
         if (req & ~gnt) begin
            addr_reg  <= addr;
            we_reg    <= we;
            be_reg    <= be;
            wdata_reg <= wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         now_reg    <= '0;
         fired_reg  <= 1'b0;
         err_pulse  <= '0;
         err_sticky <= '0;
         n_reads    <= '0;
         n_writes   <= '0;
      end else begin
         now_reg    <= now_reg + CNT_WIDTH'(1);
         err_pulse  <= err_next;
         err_sticky <= err_sticky | err_next;
         if (pop) begin
            fired_reg <= 1'b0;
         end else if (timeout_hit) begin
            fired_reg <= 1'b1;
         end
         if (pop) begin
            if (head[EW-1]) begin
               n_writes <= sat_inc(n_writes);
            end else begin
               n_reads <= sat_inc(n_reads);
            end
         end
      end
   end

endmodule

// File: tb/tb_uvmt_obi_st_prot_chkr.sv
// Directed bench: instance a (depth 4, timeout 8, rvalid-only completion) and
// instance b (depth 2, no timeout, rvalid&rready completion) share stimulus.
module tb_uvmt_obi_st_prot_chkr;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic        gnt = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        rvalid = 1'b0;
   logic        rready = 1'b0;

   logic [4:0]  a_err_pulse, a_err_sticky, a_outstanding;
   logic [31:0] a_n_reads, a_n_writes;
   logic [4:0]  b_err_pulse, b_err_sticky, b_outstanding;
   logic [31:0] b_n_reads, b_n_writes;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   uvmt_obi_st_prot_chkr #(
      .ADDR_WIDTH (32), .DATA_WIDTH (32), .MAX_OUTSTANDING (4),
      .RSP_TIMEOUT (8), .USE_RREADY (1'b0)
   ) u_a (
      .clk (clk), .reset_n (reset_n), .req (req), .gnt (gnt), .we (we),
      .addr (addr), .be (be), .wdata (wdata), .rvalid (rvalid), .rready (rready),
      .err_pulse (a_err_pulse), .err_sticky (a_err_sticky), .outstanding (a_outstanding),
      .n_reads (a_n_reads), .n_writes (a_n_writes)
   );

   uvmt_obi_st_prot_chkr #(
      .ADDR_WIDTH (32), .DATA_WIDTH (32), .MAX_OUTSTANDING (2),
      .RSP_TIMEOUT (0), .USE_RREADY (1'b1)
   ) u_b (
      .clk (clk), .reset_n (reset_n), .req (req), .gnt (gnt), .we (we),
      .addr (addr), .be (be), .wdata (wdata), .rvalid (rvalid), .rready (rready),
      .err_pulse (b_err_pulse), .err_sticky (b_err_sticky), .outstanding (b_outstanding),
      .n_reads (b_n_reads), .n_writes (b_n_writes)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance one edge; outputs are then sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic g, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      req = r; gnt = g; we = w; addr = a; be = b; wdata = d;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rvalid = 1'b0;
      rready = 1'b0;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_err_pulse", 32'(a_err_pulse), 32'h0);
      check("rst_err_sticky", 32'(a_err_sticky), 32'h0);
      check("rst_outstanding", 32'(a_outstanding), 32'h0);
      check("rst_n_reads", a_n_reads, 32'h0);
      check("rst_n_writes", a_n_writes, 32'h0);

      // Address changes while stalled
      drive(1'b1, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0);
      tick();
      check("stab_first_cycle", 32'(a_err_pulse), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h104, 4'hF, 32'h0);
      tick();
      check("stab_addr_pulse", 32'(a_err_pulse), 32'h01);
      check("stab_addr_sticky", 32'(a_err_sticky), 32'h01);
      drive(1'b1, 1'b1, 1'b0, 32'h104, 4'hF, 32'h0);
      tick();
      check("stab_hold_ok", 32'(a_err_pulse), 32'h0);
      check("stab_accept_outst", 32'(a_outstanding), 32'h1);

      // Read may change wdata while stalled; write may not
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'h200, 4'hF, 32'h1);
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h2);
      tick();
      check("stab_read_wdata", 32'(a_err_pulse), 32'h0);
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 32'h200, 4'hF, 32'h1);
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'h200, 4'hF, 32'h2);
      tick();
      check("stab_write_wdata", 32'(a_err_pulse), 32'h01);
      // Dropping req after a stall
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'h300, 4'h3, 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h300, 4'h3, 32'h0);
      tick();
      check("stab_req_drop", 32'(a_err_pulse), 32'h01);

      // Four writes then four responses
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b1, 32'h1000 + 32'(4 * i), 4'hF, 32'(i));
         tick();
         check($sformatf("wr_fill_outst%0d", i), 32'(a_outstanding), 32'(i + 1));
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("wr_drain_outst%0d", i), 32'(a_outstanding), 32'(3 - i));
      end
      rvalid = 1'b0;
      tick();
      check("wr_n_writes", a_n_writes, 32'd4);
      check("wr_n_reads", a_n_reads, 32'd0);
      check("wr_sticky", 32'(a_err_sticky), 32'h0);

      // Full FIFO: accept with same-cycle response
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h2000 + 32'(4 * i), 4'hF, 32'h0);
         tick();
      end
      check("full_outst", 32'(a_outstanding), 32'h4);
      drive(1'b1, 1'b1, 1'b1, 32'h3000, 4'hF, 32'hAB);
      rvalid = 1'b1;
      tick();
      check("full_swap_pulse", 32'(a_err_pulse), 32'h0);
      check("full_swap_outst", 32'(a_outstanding), 32'h4);
      check("full_swap_reads", a_n_reads, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      rvalid = 1'b0;
      tick();
      check("full_drain_reads", a_n_reads, 32'd4);
      check("full_drain_writes", a_n_writes, 32'd1);
      check("full_drain_sticky", 32'(a_err_sticky), 32'h0);

      // Overflow on a full depth-4 FIFO
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h4000, 4'hF, 32'h0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      check("ovf4_pulse", 32'(a_err_pulse), 32'h04);
      check("ovf4_outst", 32'(a_outstanding), 32'h4);

      // Zero byte-enable is flagged but tracked
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 32'h5000, 4'h0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      check("zero_be_pulse", 32'(a_err_pulse), 32'h08);
      check("zero_be_outst", 32'(a_outstanding), 32'h1);

      // Timeout of 8: fires once, 8 cycles after accept
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 32'h6000, 4'hF, 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      for (int i = 0; i < 7; i++) begin
         tick();
      end
      check("to_before", 32'(a_err_pulse), 32'h0);
      tick();
      check("to_fire", 32'(a_err_pulse), 32'h10);
      tick();
      check("to_once", 32'(a_err_pulse), 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      check("to_no_refire", 32'(a_err_pulse), 32'h0);
      rvalid = 1'b1;
      tick();
      rvalid = 1'b0;
      check("to_drain_outst", 32'(a_outstanding), 32'h0);
      check("to_n_reads", a_n_reads, 32'd1);
      check("to_sticky", 32'(a_err_sticky), 32'h10);

      // Unexpected response with nothing outstanding
      do_reset();
      rvalid = 1'b1;
      tick();
      rvalid = 1'b0;
      check("unexp_pulse", 32'(a_err_pulse), 32'h02);
      check("unexp_outst", 32'(a_outstanding), 32'h0);
      check("unexp_reads", a_n_reads, 32'd0);

      // Depth-2 instance: overflow on the third accept
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 32'h7000, 4'hF, 32'h0);
      tick();
      check("ovf2_first", 32'(b_err_pulse), 32'h0);
      tick();
      check("ovf2_second_outst", 32'(b_outstanding), 32'h2);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      check("ovf2_pulse", 32'(b_err_pulse), 32'h04);
      check("ovf2_outst", 32'(b_outstanding), 32'h2);

      // rready gating: rvalid alone does not complete
      rvalid = 1'b1;
      rready = 1'b0;
      tick();
      check("rr_hold_pulse", 32'(b_err_pulse), 32'h0);
      check("rr_hold_outst", 32'(b_outstanding), 32'h2);
      check("rr_hold_reads", b_n_reads, 32'd0);
      rready = 1'b1;
      tick();
      rvalid = 1'b0;
      rready = 1'b0;
      check("rr_done_outst", 32'(b_outstanding), 32'h1);
      check("rr_done_reads", b_n_reads, 32'd1);
      check("rr_no_timeout", 32'(b_err_sticky), 32'h04);

      // Asynchronous reset mid-transaction
      #3;
      reset_n = 1'b0;
      #1;
      check("async_rst_outst", 32'(b_outstanding), 32'h0);
      check("async_rst_sticky", 32'(b_err_sticky), 32'h0);
      check("async_rst_reads", b_n_reads, 32'd0);
      reset_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
